// File: rtl/misc_unit_px.sv
// Two-stage misc-operation unit: BCD adjust, negate, bit reverse, count/index ops.
// Valid/ready pipeline with backpressure and destination-tag passthrough.
module misc_unit_px #(
    parameter int W    = 64,
    parameter int TAGW = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ACT,
    output logic            ACK,
    input  logic [2:0]      OpCODE,
    input  logic [2:0]      SA,
    input  logic [TAGW-1:0] DSTi,
    input  logic [W/4-1:0]  CIN,
    input  logic [W-1:0]    A,
    input  logic            ORDY,
    output logic            RDY,
    output logic [TAGW-1:0] DSTo,
    output logic [W-1:0]    R,
    output logic            ZERO,
    output logic            SIGN,
    output logic            COUT
);

    localparam int NB = W / 4;
    localparam int SW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        OP_DAA, OP_DAS, OP_BREV, OP_NEG,
        OP_POPCNT, OP_CLZ, OP_POS, OP_LOOP
    } op_e;

    logic v1, v2, adv1, adv2, take;
    op_e             op1;
    logic [SW-1:0]   sz1;
    logic [W-1:0]    a1;
    logic [NB-1:0]   adj1;
    logic [TAGW-1:0] tag1;

    assign adv2 = ~v2 | ORDY;
    assign adv1 = v1 & adv2;
    assign ACK  = ~v1 | adv2;
    assign take = ACT & ACK;
    assign RDY  = v2;

    // Stage 1 input side: effective size, masked operand, per-nibble adjust
    int            sz_in;
    logic [W-1:0]  msk_in;
    logic [NB-1:0] adj_in;
    logic          dc, big, nine;
    logic [3:0]    d;

    always_comb begin
        sz_in = 8 << SA;
        if (sz_in > W) sz_in = W;
        msk_in = '0;
        for (int j = 0; j < W; j++) msk_in[j] = (j < sz_in);
        adj_in = '0;
        dc = 1'b0;
        big = 1'b0;
        nine = 1'b0;
        d = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < sz_in / 4) begin
                d    = A[4*i +: 4];
                big  = d > 4'd9;
                nine = d == 4'd9;
                if (OpCODE == OP_DAS) adj_in[i] = CIN[i];
                else adj_in[i] = CIN[i] | big | (nine & dc);
                dc = big | (nine & dc);
            end
        end
    end

    // Stage 2 input side: final result and flags from the S1 registers
    int           sz, hi, ones;
    logic [W-1:0] msk, six, rev, res, tmp;
    logic [NB-1:0] tadj;
    logic         any, z, sg, co;

    always_comb begin
        sz = int'(sz1);
        msk = '0;
        for (int j = 0; j < W; j++) msk[j] = (j < sz);
        six = '0;
        for (int i = 0; i < NB; i++) six[4*i +: 4] = adj1[i] ? 4'h6 : 4'h0;
        rev = '0;
        for (int j = 0; j < W; j++) rev[j] = a1[W-1-j];
        hi = 0;
        ones = 0;
        for (int j = 0; j < W; j++) begin
            if (a1[j]) begin
                hi = j;
                ones = ones + 1;
            end
        end
        any = |a1;
        tadj = adj1 >> (sz / 4 - 1);
        res = '0;
        co = 1'b0;
        unique case (op1)
            OP_DAA:    begin res = (a1 + six) & msk; co = tadj[0]; end
            OP_DAS:    begin res = (a1 - six) & msk; co = tadj[0]; end
            OP_BREV:   res = rev >> (W - sz);
            OP_NEG:    begin res = (~a1 + 1'b1) & msk; co = any; end
            OP_POPCNT: res = W'(ones);
            OP_CLZ:    res = any ? W'(sz - 1 - hi) : W'(sz);
            OP_POS:    res = W'(hi);
            OP_LOOP:   begin res = (a1 - 1'b1) & msk; co = ~any; end
        endcase
        tmp = res >> (sz - 1);
        z  = (op1 == OP_POS) ? ~any : (res == '0);
        sg = (op1 == OP_POPCNT || op1 == OP_CLZ || op1 == OP_POS)
             ? 1'b0 : tmp[0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            op1  <= OP_DAA;
            sz1  <= '0;
            a1   <= '0;
            adj1 <= '0;
            tag1 <= '0;
            R    <= '0;
            DSTo <= '0;
            ZERO <= 1'b0;
            SIGN <= 1'b0;
            COUT <= 1'b0;
        end else begin
            v1 <= take | (v1 & ~adv2);
            v2 <= adv1 | (v2 & ~ORDY);
            if (take) begin
                op1  <= op_e'(OpCODE);
                sz1  <= SW'(sz_in);
                a1   <= A & msk_in;
                adj1 <= adj_in;
                tag1 <= DSTi;
            end
            if (adv1) begin
                R    <= res;
                DSTo <= tag1;
                ZERO <= z;
                SIGN <= sg;
                COUT <= co;
            end
        end
    end

endmodule

// File: tb/tb_misc_unit_px.sv
// Bench for misc_unit_px: directed vectors, backpressure, reset and random
// traffic against a behavioural model (W=64), plus a W=128 instance.
module tb_misc_unit_px;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, act, ordy, ack, rdy, zf, sf, cf;
    logic [2:0]  op, sa;
    logic [3:0]  tag, dsto;
    logic [15:0] cin;
    logic [63:0] a, r;

    logic         act2, ordy2, ack2, rdy2, z2, s2, c2;
    logic [2:0]   op2, sa2;
    logic [3:0]   tag2, dsto2;
    logic [31:0]  cin2;
    logic [127:0] a2, r2;

    misc_unit_px #(.W(64), .TAGW(4)) dut (
        .CLK(clk), .RESET(rst), .ACT(act), .ACK(ack), .OpCODE(op), .SA(sa),
        .DSTi(tag), .CIN(cin), .A(a), .ORDY(ordy), .RDY(rdy), .DSTo(dsto),
        .R(r), .ZERO(zf), .SIGN(sf), .COUT(cf)
    );

    misc_unit_px #(.W(128), .TAGW(4)) dut128 (
        .CLK(clk), .RESET(rst), .ACT(act2), .ACK(ack2), .OpCODE(op2), .SA(sa2),
        .DSTi(tag2), .CIN(cin2), .A(a2), .ORDY(ordy2), .RDY(rdy2), .DSTo(dsto2),
        .R(r2), .ZERO(z2), .SIGN(s2), .COUT(c2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sa;
        logic [63:0] a;
        logic [15:0] cin;
        logic [63:0] r;
        bit z, s, c;
    } vec_t;

    typedef struct {
        logic [63:0] r;
        bit z, s, c;
        logic [3:0] tag;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic [2:0] o, input logic [2:0] s_a,
                                   input logic [63:0] av, input logic [15:0] cv,
                                   input logic [3:0] tg);
        exp_t e;
        int s, n;
        logic [63:0] m, x, rr, sum;
        bit carry, adj, co;
        logic [3:0] dg;
        s = 8 << s_a;
        if (s > 64) s = 64;
        n = s / 4;
        m = (s == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << s) - 64'd1);
        x = av & m;
        rr = 0;
        co = 0;
        sum = 0;
        carry = 0;
        case (o)
            3'd0: begin
                for (int i = 0; i < n; i++) begin
                    dg = x[4*i +: 4];
                    adj = cv[i] || dg > 9 || (dg == 9 && carry);
                    carry = dg > 9 || (dg == 9 && carry);
                    if (adj) sum = sum + (64'd6 << (4 * i));
                    co = adj;
                end
                rr = (x + sum) & m;
            end
            3'd1: begin
                for (int i = 0; i < n; i++)
                    if (cv[i]) sum = sum + (64'd6 << (4 * i));
                rr = (x - sum) & m;
                co = cv[n-1];
            end
            3'd2: for (int j = 0; j < s; j++) rr[j] = x[s-1-j];
            3'd3: begin rr = (64'd0 - x) & m; co = (x != 0); end
            3'd4: rr = 64'($countones(x));
            3'd5: begin
                int k;
                k = s - 1;
                while (k >= 0 && !x[k]) begin rr = rr + 1; k--; end
            end
            3'd6: for (int j = 0; j < s; j++) if (x[j]) rr = 64'(j);
            default: begin rr = (x - 64'd1) & m; co = (x == 0); end
        endcase
        e.r = rr;
        e.c = co;
        e.z = (o == 3'd6) ? (x == 0) : (rr == 0);
        e.s = (o >= 3'd4 && o <= 3'd6) ? 1'b0 : rr[s-1];
        e.tag = tg;
        return e;
    endfunction

    task automatic run_one(input vec_t v, input string nm);
        int lat;
        bit got;
        op = v.op; sa = v.sa; a = v.a; cin = v.cin;
        tag = tag + 1; act = 1; ordy = 1;
        @(negedge clk);
        chk({nm, "_ack"}, ack, 1);
        @(posedge clk); #1;
        act = 0;
        lat = 0;
        got = 0;
        while (!got && lat < 8) begin
            lat++;
            @(negedge clk);
            if (rdy) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk({nm, "_lat"}, lat, 2);
        chk({nm, "_r"}, r, v.r);
        chk({nm, "_z"}, zf, v.z);
        chk({nm, "_s"}, sf, v.s);
        chk({nm, "_c"}, cf, v.c);
        chk({nm, "_tag"}, dsto, tag);
        @(posedge clk); #1;
    endtask

    task automatic run128(input logic [2:0] o, input logic [2:0] s_a,
                          input logic [127:0] av, input logic [31:0] cv,
                          input logic [127:0] er, input bit ez, es, ec,
                          input string nm);
        op2 = o; sa2 = s_a; a2 = av; cin2 = cv; tag2 = tag2 + 1;
        act2 = 1; ordy2 = 1;
        @(negedge clk);
        chk({nm, "_ack"}, ack2, 1);
        @(posedge clk); #1;
        act2 = 0;
        @(negedge clk);
        chk({nm, "_early"}, rdy2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_rdy"}, rdy2, 1);
        chk({nm, "_r"}, r2, er);
        chk({nm, "_z"}, z2, ez);
        chk({nm, "_s"}, s2, es);
        chk({nm, "_c"}, c2, ec);
        chk({nm, "_tag"}, dsto2, tag2);
        @(posedge clk); #1;
    endtask

    vec_t tv[17];

    initial begin
        int acc, occ;
        exp_t e;

        tv[0]  = '{3'd0, 3'd0, 64'h9A, 16'h0, 64'h0, 1, 0, 1};
        tv[1]  = '{3'd3, 3'd1, 64'h1, 16'h0, 64'hFFFF, 0, 1, 1};
        tv[2]  = '{3'd7, 3'd1, 64'h0, 16'h0, 64'hFFFF, 0, 1, 1};
        tv[3]  = '{3'd2, 3'd0, 64'hFF01, 16'h0, 64'h80, 0, 1, 0};
        tv[4]  = '{3'd4, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0, 64'd64, 0, 0, 0};
        tv[5]  = '{3'd5, 3'd2, 64'h0001_0000, 16'h0, 64'd15, 0, 0, 0};
        tv[6]  = '{3'd6, 3'd2, 64'h0, 16'h0, 64'h0, 1, 0, 0};
        tv[7]  = '{3'd1, 3'd1, 64'h1234, 16'h0005, 64'h0C2E, 0, 0, 0};
        tv[8]  = '{3'd5, 3'd0, 64'h0, 16'h0, 64'd8, 0, 0, 0};
        tv[9]  = '{3'd6, 3'd7, 64'h8000_0000_0000_0000, 16'h0, 64'd63, 0, 0, 0};
        tv[10] = '{3'd3, 3'd0, 64'h100, 16'h0, 64'h0, 1, 0, 0};
        tv[11] = '{3'd0, 3'd1, 64'h0999, 16'h0001, 64'h099F, 0, 0, 0};
        tv[12] = '{3'd0, 3'd1, 64'h099A, 16'h0, 64'h1000, 0, 0, 0};
        tv[13] = '{3'd7, 3'd2, 64'h8000_0000, 16'h0, 64'h7FFF_FFFF, 0, 0, 0};
        tv[14] = '{3'd4, 3'd1, 64'hFFFF_0F0F, 16'h0, 64'd8, 0, 0, 0};
        tv[15] = '{3'd1, 3'd0, 64'h0, 16'hFF03, 64'h9A, 0, 1, 1};
        tv[16] = '{3'd0, 3'd0, 64'h99, 16'h0, 64'h99, 0, 1, 0};

        rst = 1; act = 0; ordy = 0; op = 0; sa = 0; a = 0; cin = 0; tag = 0;
        act2 = 0; ordy2 = 0; op2 = 0; sa2 = 0; a2 = 0; cin2 = 0; tag2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_ack", ack, 1);
        chk("rst_r", r, 0);
        chk("rst_tag", dsto, 0);
        chk("rst_flags", {zf, sf, cf}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_one(tv[i], $sformatf("vec%0d", i));

        // backpressure: three ops offered while downstream stalls
        ordy = 0; act = 1; op = 3'd4; sa = 3'd3; cin = 0;
        tag = 1; a = 64'h1;
        acc = 0;
        @(negedge clk); chk("bp_ack0", ack, 1); acc += int'(ack);
        @(posedge clk); #1; tag = 2; a = 64'h3;
        @(negedge clk); chk("bp_ack1", ack, 1); chk("bp_rdy1", rdy, 0);
        acc += int'(ack);
        @(posedge clk); #1; tag = 3; a = 64'h7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            acc += int'(ack);
            chk("bp_stall_ack", ack, 0);
            chk("bp_stall_rdy", rdy, 1);
            chk("bp_stall_tag", dsto, 1);
            chk("bp_stall_r", r, 1);
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc, 2);
        ordy = 1;
        @(negedge clk);
        chk("bp_go_ack", ack, 1);
        chk("bp_out1_tag", dsto, 1); chk("bp_out1_r", r, 1);
        @(posedge clk); #1; act = 0;
        @(negedge clk);
        chk("bp_out2_rdy", rdy, 1);
        chk("bp_out2_tag", dsto, 2); chk("bp_out2_r", r, 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_out3_rdy", rdy, 1);
        chk("bp_out3_tag", dsto, 3); chk("bp_out3_r", r, 3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_empty", rdy, 0);
        @(posedge clk); #1;

        // reset with both stages full
        ordy = 0; act = 1; op = 3'd3; sa = 3'd1; a = 64'h5; tag = 5;
        @(posedge clk); #1; tag = 6;
        @(posedge clk); #1; act = 0;
        @(negedge clk);
        chk("rf_full_rdy", rdy, 1);
        chk("rf_full_ack", ack, 0);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("rf_rdy", rdy, 0);
        chk("rf_ack", ack, 1);
        chk("rf_r", r, 0);
        chk("rf_tag", dsto, 0);
        chk("rf_flags", {zf, sf, cf}, 0);
        ordy = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rf_nothing", rdy, 0);
        end
        @(posedge clk); #1;

        // W=128 instance
        run128(3'd1, 3'd4, {32{4'h7}}, 32'hFFFF_FFFF, {32{4'h1}}, 0, 0, 1, "w128_das");
        run128(3'd2, 3'd7, 128'h1, 32'h0, {1'b1, 127'h0}, 0, 1, 0, "w128_brev");

        // random traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            act  = $urandom_range(0, 99) < 70;
            ordy = $urandom_range(0, 99) < 65;
            op   = 3'($urandom);
            sa   = 3'($urandom);
            cin  = 16'($urandom);
            tag  = 4'($urandom);
            case ($urandom_range(0, 3))
                0: a = 64'h0;
                1: for (int i = 0; i < 16; i++) a[4*i +: 4] = 4'(8 + $urandom_range(0, 2));
                default: a = {$urandom, $urandom};
            endcase
            @(negedge clk);
            occ = q.size();
            chk("rnd_ack", ack, (occ < 2) || ordy);
            if (occ == 2) chk("rnd_rdy_full", rdy, 1);
            if (rdy) begin
                if (q.size() == 0) chk("rnd_spurious", rdy, 0);
                else begin
                    e = q[0];
                    chk("rnd_r", r, e.r);
                    chk("rnd_flags", {zf, sf, cf}, {e.z, e.s, e.c});
                    chk("rnd_tag", dsto, e.tag);
                end
            end
            if (rdy && ordy && q.size() > 0) void'(q.pop_front());
            if (act && ack) q.push_back(model(op, sa, a, cin, tag));
            @(posedge clk); #1;
        end
        act = 0; ordy = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy) begin
                if (q.size() == 0) chk("drain_spurious", rdy, 0);
                else begin
                    e = q.pop_front();
                    chk("drain_r", r, e.r);
                    chk("drain_tag", dsto, e.tag);
                end
            end
            @(posedge clk); #1;
        end
        chk("drain_left", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
